// File: rtl/stream_profiler_pkg.sv
// Shared definitions for the stream phase profiler: phase encoding and default token.
package stream_profiler_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_WRITE = 3'd1,
        PH_GAP   = 3'd2,
        PH_READ  = 3'd3,
        PH_DONE  = 3'd4
    } phase_e;

    localparam logic [16:0] DEFAULT_DONE_TOKEN = 17'h10100;

endpackage

// File: rtl/stream_phase_profiler_if.sv
// Passive tap bundle for the producer and consumer streams watched by the profiler.
interface stream_phase_profiler_if #(
    parameter int DATA_W  = 17,
    parameter int NUM_IN  = 2,
    parameter int NUM_OUT = 2
) ();

    logic [NUM_IN-1:0][DATA_W-1:0]  in_data;
    logic [NUM_IN-1:0]              in_valid;
    logic [NUM_IN-1:0]              in_ready;
    logic [NUM_OUT-1:0][DATA_W-1:0] out_data;
    logic [NUM_OUT-1:0]             out_valid;
    logic [NUM_OUT-1:0]             out_ready;

    modport master (
        output in_data, in_valid, in_ready,
        output out_data, out_valid, out_ready
    );

    modport slave (
        input in_data, in_valid, in_ready,
        input out_data, out_valid, out_ready
    );

endinterface

// File: rtl/stream_phase_profiler_sat_counter.sv
// Saturating up-counter with synchronous clear, enable-gated increment and sticky overflow flag.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             sat
);

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (en && inc) begin
            count <= sat_inc(count);
            if (&count) sat <= 1'b1;
        end
    end

endmodule

// File: rtl/stream_phase_profiler.sv
// Observes a write/gap/read streaming job and reports per-phase cycle counts.
// Optional per-consumer stall counters are built when PROFILER_STALL_CNT_EN is defined.
module stream_phase_profiler
    import stream_profiler_pkg::*;
#(
    parameter int                DATA_W     = 17,
    parameter int                NUM_IN     = 2,
    parameter int                NUM_OUT    = 2,
    parameter int                CNT_W      = 32,
    parameter logic [DATA_W-1:0] DONE_TOKEN = DATA_W'(DEFAULT_DONE_TOKEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    stream_phase_profiler_if.slave  taps,
    input  logic [15:0]             cfg_wait_gap,
    output logic [CNT_W-1:0]        write_cycles,
    output logic [CNT_W-1:0]        gap_cycles,
    output logic [CNT_W-1:0]        read_cycles,
    output logic [2:0]              phase,
    output logic                    done,
    output logic                    saturated
`ifdef PROFILER_STALL_CNT_EN
    ,
    output logic [NUM_OUT-1:0][CNT_W-1:0] stall_cycles
`endif
);

    phase_e               state_q, state_d;
    logic [15:0]          gap_q;
    logic                 rd_seen_q, rd_seen, rd_any;
    logic [NUM_OUT-1:0]   done_bits_q, tok_rd;
    logic                 tok_wr;
    logic                 wr_inc, gap_inc, rd_inc;
    logic                 sat_wr, sat_gap, sat_rd, sat_stall;

    assign tok_wr = taps.in_valid[0] & taps.in_ready[0] & (taps.in_data[0] == DONE_TOKEN);

    always_comb begin
        tok_rd = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            tok_rd[j] = taps.out_valid[j] & taps.out_ready[j] & (taps.out_data[j] == DONE_TOKEN);
        end
    end

    // A single-channel producer has no read-request channel, so the read side counts as always seen.
    if (NUM_IN > 1) begin : g_rd_multi
        assign rd_any  = |taps.in_valid[NUM_IN-1:1];
        assign rd_seen = rd_seen_q;
    end else begin : g_rd_single
        assign rd_any  = 1'b0;
        assign rd_seen = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        wr_inc  = 1'b0;
        gap_inc = 1'b0;
        rd_inc  = 1'b0;
        case (state_q)
            PH_IDLE: begin
                if (taps.in_valid[0]) begin
                    state_d = PH_WRITE;
                    wr_inc  = 1'b1;
                end
            end
            PH_WRITE: begin
                wr_inc = 1'b1;
                if (tok_wr) state_d = PH_GAP;
            end
            PH_GAP: begin
                gap_inc = 1'b1;
                if (gap_q == '0 && rd_seen) state_d = PH_READ;
            end
            PH_READ: begin
                rd_inc = ~(&done_bits_q);
                if (&(done_bits_q | tok_rd)) state_d = PH_DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PH_IDLE;
            gap_q       <= '0;
            rd_seen_q   <= 1'b0;
            done_bits_q <= '0;
        end else if (clk_en) begin
            state_q   <= state_d;
            rd_seen_q <= rd_seen_q | rd_any;
            if (state_q == PH_WRITE && state_d == PH_GAP) begin
                gap_q <= cfg_wait_gap;
            end else if (state_q == PH_GAP && gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end
            if (state_q == PH_READ) done_bits_q <= done_bits_q | tok_rd;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_write_cnt (
        .clk(clk), .clear(rst), .en(clk_en), .inc(wr_inc), .count(write_cycles), .sat(sat_wr)
    );
    sat_counter #(.WIDTH(CNT_W)) u_gap_cnt (
        .clk(clk), .clear(rst), .en(clk_en), .inc(gap_inc), .count(gap_cycles), .sat(sat_gap)
    );
    sat_counter #(.WIDTH(CNT_W)) u_read_cnt (
        .clk(clk), .clear(rst), .en(clk_en), .inc(rd_inc), .count(read_cycles), .sat(sat_rd)
    );

`ifdef PROFILER_STALL_CNT_EN
    logic [NUM_OUT-1:0] sat_st;
    for (genvar j = 0; j < NUM_OUT; j++) begin : g_stall
        sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
            .clk   (clk),
            .clear (rst),
            .en    (clk_en),
            .inc   ((state_q == PH_READ) & taps.out_valid[j] & ~taps.out_ready[j]),
            .count (stall_cycles[j]),
            .sat   (sat_st[j])
        );
    end
    assign sat_stall = |sat_st;
`else
    assign sat_stall = 1'b0;
`endif

    assign phase     = state_q;
    assign done      = (state_q == PH_DONE);
    assign saturated = sat_wr | sat_gap | sat_rd | sat_stall;

endmodule
